// File: rtl/pipe_wb_regfile.sv
// Writeback-stage source mux and 31-entry register file with write-through
// bypass, a committed-writeback counter and a sticky illegal-select flag.
module pipe_wb_regfile #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wb_alu_out,
  input  logic [31:0]      wb_dmem_out,
  input  logic [31:0]      wb_pc4,
  input  logic [31:0]      wb_rs_data_out,
  input  logic [4:0]       wb_rf_waddr,
  input  logic             wb_rf_wena,
  input  logic [2:0]       wb_rf_mux_sel,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [31:0]      rdata1,
  output logic [31:0]      rdata2,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             sel_err
);

  logic [31:0] regs [31:1];
  logic        rst_hold;
  logic        commit;
  logic        illegal;
  logic        reg_write;

  // Bypass-aware read of one port; address 0 and reset always read zero.
  function automatic logic [31:0] read_port(
    input logic [4:0]  addr,
    input logic [31:0] stored,
    input logic        wr,
    input logic [4:0]  waddr,
    input logic [31:0] wdata,
    input logic        in_rst
  );
    logic [31:0] val;
    if (in_rst || (addr == 5'd0)) begin
      val = 32'h0;
    end else if (wr && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Writeback source select; codes 4-7 are illegal and yield zero.
  always_comb begin
    wb_data = 32'h0;
    case (wb_rf_mux_sel)
      3'd0:    wb_data = wb_alu_out;
      3'd1:    wb_data = wb_dmem_out;
      3'd2:    wb_data = wb_pc4;
      3'd3:    wb_data = wb_rs_data_out;
      default: wb_data = 32'h0;
    endcase
  end

  // rst_hold stays high through the first edge after reset release, so a
  // commit presented on that edge is dropped deterministically.
  always_comb begin
    commit    = wb_rf_wena && (wb_rf_mux_sel <= 3'd3) && !rst_hold;
    illegal   = wb_rf_wena && (wb_rf_mux_sel >  3'd3) && !rst_hold;
    reg_write = commit && (wb_rf_waddr != 5'd0);
  end

  // Reset-release qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_hold <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
    end
  end

  // Register storage x1..x31.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (reg_write) begin
      regs[wb_rf_waddr] <= wb_data;
    end
  end

  // Committed-writeback counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (commit) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Sticky illegal-select flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (illegal) begin
      sel_err <= 1'b1;
    end
  end

  // Read ports.
  always_comb begin
    rdata1 = read_port(raddr1, (raddr1 == 5'd0) ? 32'h0 : regs[raddr1],
                       reg_write, wb_rf_waddr, wb_data, rst);
    rdata2 = read_port(raddr2, (raddr2 == 5'd0) ? 32'h0 : regs[raddr2],
                       reg_write, wb_rf_waddr, wb_data, rst);
  end

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Directed scoreboard bench for pipe_wb_regfile (instantiated with a 4-bit
// retire counter so counter wrap is reachable).
module tb_pipe_wb_regfile;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   wb_alu_out, wb_dmem_out, wb_pc4, wb_rs_data_out;
  logic [4:0]    wb_rf_waddr;
  logic          wb_rf_wena;
  logic [2:0]    wb_rf_mux_sel;
  logic [4:0]    raddr1, raddr2;
  logic [31:0]   rdata1, rdata2, wb_data;
  logic [CW-1:0] retire_cnt;
  logic          sel_err;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [CW-1:0] model_cnt = '0;

  pipe_wb_regfile #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .wb_alu_out(wb_alu_out), .wb_dmem_out(wb_dmem_out),
    .wb_pc4(wb_pc4), .wb_rs_data_out(wb_rs_data_out),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wena(wb_rf_wena),
    .wb_rf_mux_sel(wb_rf_mux_sel),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .wb_data(wb_data),
    .retire_cnt(retire_cnt), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wena, input logic [2:0] sel,
                       input logic [4:0] waddr, input logic [31:0] alu);
    wb_rf_wena    = wena;
    wb_rf_mux_sel = sel;
    wb_rf_waddr   = waddr;
    wb_alu_out    = alu;
    if (wena && sel <= 3'd3) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic check_cnt(input string tag);
    push(tag, 32'(model_cnt));
    pop_check(32'(retire_cnt));
  endtask

  initial begin
    rst = 1'b1;
    wb_alu_out = 32'h0; wb_dmem_out = 32'h0; wb_pc4 = 32'h0; wb_rs_data_out = 32'h0;
    wb_rf_waddr = 5'd0; wb_rf_wena = 1'b0; wb_rf_mux_sel = 3'd0;
    raddr1 = 5'd1; raddr2 = 5'd2;
    #2;
    push("reset_cnt", 32'h0);    pop_check(32'(retire_cnt));
    push("reset_selerr", 32'h0); pop_check(32'(sel_err));
    push("reset_rdata1", 32'h0); pop_check(rdata1);
    #10 rst = 1'b0;
    tick(); tick();

    // Source select decode into x5, bypass visible each cycle.
    wb_dmem_out = 32'h22; wb_pc4 = 32'h33; wb_rs_data_out = 32'h44;
    raddr1 = 5'd5;
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 3'(s), 5'd5, 32'h11);
      #1;
      push($sformatf("sel%0d_wbdata", s), 32'h11 * (s + 1)); pop_check(wb_data);
      push($sformatf("sel%0d_bypass", s), 32'h11 * (s + 1)); pop_check(rdata1);
      tick();
    end
    drive(1'b0, 3'd4, 5'd5, 32'h11);
    #1;
    push("x5_stored", 32'h44); pop_check(rdata1);
    push("sel4_wbdata", 32'h0); pop_check(wb_data);
    check_cnt("cnt_after_sel_decode");

    // Bypass on both ports with equal addresses.
    drive(1'b1, 3'd0, 5'd7, 32'hAAAA);
    tick();
    drive(1'b0, 3'd0, 5'd7, 32'h5555);
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    push("x7_old", 32'hAAAA); pop_check(rdata1);
    drive(1'b1, 3'd0, 5'd7, 32'h5555);
    #1;
    push("bypass_p1", 32'h5555); pop_check(rdata1);
    push("bypass_p2", 32'h5555); pop_check(rdata2);
    tick();
    drive(1'b0, 3'd0, 5'd7, 32'h0);
    #1;
    push("x7_new_p1", 32'h5555); pop_check(rdata1);
    push("x7_new_p2", 32'h5555); pop_check(rdata2);
    check_cnt("cnt_after_bypass");

    // x0 is never written but the commit still counts.
    raddr1 = 5'd0;
    drive(1'b1, 3'd0, 5'd0, 32'hFFFF_FFFF);
    #1;
    push("x0_same_cycle", 32'h0); pop_check(rdata1);
    tick();
    drive(1'b0, 3'd0, 5'd0, 32'h0);
    #1;
    push("x0_next_cycle", 32'h0); pop_check(rdata1);
    check_cnt("cnt_after_x0");

    // Illegal select suppresses the write and latches sel_err.
    drive(1'b1, 3'd0, 5'd3, 32'h10);
    tick();
    raddr1 = 5'd3;
    drive(1'b1, 3'd5, 5'd3, 32'h99);
    #1;
    push("illegal_no_bypass", 32'h10); pop_check(rdata1);
    push("selerr_before_edge", 32'h0); pop_check(32'(sel_err));
    tick();
    drive(1'b0, 3'd6, 5'd3, 32'h77);
    #1;
    push("illegal_x3_kept", 32'h10); pop_check(rdata1);
    push("selerr_set", 32'h1);       pop_check(32'(sel_err));
    check_cnt("cnt_after_illegal");
    tick(); tick();
    push("wena0_x3_kept", 32'h10); pop_check(rdata1);
    push("selerr_sticky", 32'h1);  pop_check(32'(sel_err));
    check_cnt("cnt_after_wena0");

    // Back-to-back commits to the same register.
    raddr1 = 5'd10;
    drive(1'b1, 3'd0, 5'd10, 32'h1);
    tick();
    drive(1'b1, 3'd0, 5'd10, 32'h2);
    tick();
    drive(1'b0, 3'd0, 5'd10, 32'h3);
    #1;
    push("b2b_last", 32'h2); pop_check(rdata1);

    // Counter wrap: run to 15, then one more commit returns to 0.
    while (model_cnt != 4'd15) begin
      drive(1'b1, 3'd0, 5'd0, 32'h0);
      tick();
    end
    drive(1'b0, 3'd0, 5'd0, 32'h0);
    #1;
    push("cnt_at_15", 32'd15); pop_check(32'(retire_cnt));
    drive(1'b1, 3'd0, 5'd0, 32'h0);
    tick();
    drive(1'b0, 3'd0, 5'd0, 32'h0);
    #1;
    push("cnt_wrapped", 32'd0); pop_check(32'(retire_cnt));

    // Asynchronous reset between edges, then commit on the release edge.
    raddr1 = 5'd9;
    drive(1'b1, 3'd0, 5'd9, 32'h1234);
    tick();
    drive(1'b0, 3'd0, 5'd9, 32'h0);
    #1;
    push("x9_stored", 32'h1234); pop_check(rdata1);
    #2 rst = 1'b1;
    #1;
    push("async_rdata", 32'h0);  pop_check(rdata1);
    push("async_cnt", 32'h0);    pop_check(32'(retire_cnt));
    push("async_selerr", 32'h0); pop_check(32'(sel_err));
    drive(1'b1, 3'd0, 5'd9, 32'h5678);
    #1;
    push("rst_no_bypass", 32'h0); pop_check(rdata1);
    #2 rst = 1'b0;
    model_cnt = '0;
    tick();
    drive(1'b0, 3'd0, 5'd9, 32'h0);
    #1;
    push("release_edge_ignored", 32'h0); pop_check(rdata1);
    check_cnt("release_edge_cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_wb_regfile.md
PIPE_WB_REGFILE -- requirements
Module: pipe_wb_regfile

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 32, width of the retire counter.
REQ-002 The block SHALL have a clock clk: input, 1 bit, all state updates on its rising edge.
REQ-003 The block SHALL have a reset rst: input, 1 bit, asynchronous, active-high.
REQ-004 wb_alu_out  input  32  ALU result from the MEM/WB register.
REQ-005 wb_dmem_out  input  32  data-memory load result.
REQ-006 wb_pc4  input  32  PC+4, the link value.
REQ-007 wb_rs_data_out  input  32  forwarded rs operand, the move-type source.
REQ-008 wb_rf_waddr  input  5  destination register index.
REQ-009 wb_rf_wena  input  1  writeback request.
REQ-010 wb_rf_mux_sel  input  3  writeback source select.
REQ-011 raddr1, raddr2  input  5 each  decode-stage read addresses.
REQ-012 rdata1, rdata2  output  32 each  read data, combinational.
REQ-013 wb_data  output  32  selected writeback value, combinational.
REQ-014 retire_cnt  output  CNT_W  count of committed writebacks, registered.
REQ-015 sel_err  output  1  sticky illegal-select flag, registered.

Function
REQ-016 wb_data SHALL be driven by wb_rf_mux_sel as follows: 0 selects wb_alu_out; 1 selects wb_dmem_out; 2 selects wb_pc4; 3 selects wb_rs_data_out; 4-7 drive 32'h0.
REQ-017 A commit SHALL occur in a cycle where wb_rf_wena=1 and wb_rf_mux_sel<=3.
REQ-018 On a commit with wb_rf_waddr!=0, the register at wb_rf_waddr SHALL take wb_data at the rising clk edge.
REQ-019 Register 0 SHALL never be written, and reads of address 0 SHALL return 0 in every case.
REQ-020 rdata1 and rdata2 SHALL be combinational reads of the 31 storage registers (x1..x31).
REQ-021 Write-through bypass: when a commit targets a nonzero waddr equal to raddrN in the same cycle, rdataN SHALL equal wb_data in that cycle, not the stale stored value.
REQ-022 Both read ports SHALL bypass independently; equal raddr1 and raddr2 SHALL both return the bypassed value.
REQ-023 wb_rf_wena=1 with wb_rf_mux_sel in 4-7 SHALL suppress the register write.
REQ-024 In that same illegal-select case, sel_err SHALL be set on the next edge and hold at 1 until reset.
REQ-025 wb_rf_wena=0 SHALL cause no write, no count and no sel_err update, for any mux_sel value.
REQ-026 retire_cnt SHALL increment by 1 on every commit, including commits with waddr=0.
REQ-027 retire_cnt SHALL wrap from all-ones to 0 without a flag.
REQ-028 Write latency SHALL be one edge: the value is visible through the storage path from the cycle after the edge, and through the bypass in the write cycle itself.
REQ-029 Back-to-back commits to the same address SHALL leave the last-written value stored.
REQ-030 The block SHALL contain no other state; there is no stall input and every cycle is evaluated.

Reset
REQ-031 While rst=1, x1..x31 SHALL be forced to 0, along with retire_cnt=0 and sel_err=0, regardless of clk.
REQ-032 rdata1 and rdata2 SHALL read 0 for all addresses while rst=1, and bypass SHALL be inhibited during reset.
REQ-033 A commit presented in the same edge at which rst deasserts SHALL be ignored.
REQ-034 Assertion of rst mid-operation SHALL discard all stored values immediately (asynchronously).

Verification
REQ-035 Sel decode: wena=1, waddr=5, alu=0x11, dmem=0x22, pc4=0x33, rs=0x44, step sel 0..3 -> x5 reads 0x11, 0x22, 0x33, 0x44 on successive cycles; retire_cnt=4.
REQ-036 Bypass: x7=0xAAAA stored; commit 0x5555 to x7 with raddr1=raddr2=7 -> both rdata read 0x5555 in the write cycle and after the edge.
REQ-037 x0 protection: commit 0xFFFFFFFF to waddr=0 -> rdata1(raddr=0)=0 in the same cycle and the next; retire_cnt increments by 1.
REQ-038 Illegal select: wena=1, sel=5, waddr=3, x3=0x10 -> x3 stays 0x10, sel_err=1 after the edge and stays 1; retire_cnt unchanged; wena=0 with sel=6 -> no effect.
REQ-039 Wrap: CNT_W=4, 16 commits -> retire_cnt reads 15 then 0.
REQ-040 Async reset: write x9=0x1234, assert rst between edges -> rdata(9)=0, retire_cnt=0, sel_err=0 before the next edge; commit on the deassert edge is not stored.
